// File: rtl/guess_game_if.sv
// guess_game_if -- player/RNG/result bundle for the guess_game block.
//   rngPush   : active-low start button (release fixes the secret)
//   rngIn     : current RNG counter value
//   guessPush : active-low guess-submit button
//   guessIn   : player guess value
//   armed, tooHigh, tooLow, match, gameOver, triesLeft : game status
// master drives buttons/values and reads status; slave is the game block.
interface guess_game_if;
    logic       rngPush;
    logic [3:0] rngIn;
    logic       guessPush;
    logic [3:0] guessIn;
    logic       armed;
    logic       tooHigh;
    logic       tooLow;
    logic       match;
    logic       gameOver;
    logic [2:0] triesLeft;

    modport master (
        output rngPush, rngIn, guessPush, guessIn,
        input  armed, tooHigh, tooLow, match, gameOver, triesLeft
    );

    modport slave (
        input  rngPush, rngIn, guessPush, guessIn,
        output armed, tooHigh, tooLow, match, gameOver, triesLeft
    );
endinterface

// File: rtl/guess_game.sv
// guess_game -- number guessing game controller.
// A release of rngPush latches rngIn as the hidden secret and arms a game
// with MAX_TRIES wrong guesses allowed. Each guessPush press compares
// guessIn with the secret and reports tooHigh/tooLow/match; running out of
// tries ends the game with gameOver.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : guess_game_if.slave (buttons, values, status outputs)
module guess_game #(
    parameter int unsigned MAX_TRIES = 5
) (
    input  logic         clk,
    input  logic         rst,
    guess_game_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WIN   = 2'd2,
        LOSE  = 2'd3
    } state_e;

    localparam logic [2:0] TRIES_INIT = 3'(MAX_TRIES);

    state_e     state_q,     state_d;
    logic [3:0] secret_q,    secret_d;
    logic [2:0] tries_q,     tries_d;
    logic       too_high_q,  too_high_d;
    logic       too_low_q,   too_low_d;
    logic       match_q,     match_d;
    logic       over_q,      over_d;
    // Previous button samples; reset to 1 (released) so a button held
    // across reset does not produce a spurious event.
    logic       rng_prev_q;
    logic       guess_prev_q;

    logic       rng_rel;
    logic       guess_prs;

    assign rng_rel   = ~rng_prev_q & bus.rngPush;
    assign guess_prs = guess_prev_q & ~bus.guessPush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            secret_q     <= 4'd0;
            tries_q      <= 3'd0;
            too_high_q   <= 1'b0;
            too_low_q    <= 1'b0;
            match_q      <= 1'b0;
            over_q       <= 1'b0;
            rng_prev_q   <= 1'b1;
            guess_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            secret_q     <= secret_d;
            tries_q      <= tries_d;
            too_high_q   <= too_high_d;
            too_low_q    <= too_low_d;
            match_q      <= match_d;
            over_q       <= over_d;
            rng_prev_q   <= bus.rngPush;
            guess_prev_q <= bus.guessPush;
        end
    end

    always_comb begin
        state_d    = state_q;
        secret_d   = secret_q;
        tries_d    = tries_q;
        too_high_d = too_high_q;
        too_low_d  = too_low_q;
        match_d    = match_q;
        over_d     = over_q;

        unique case (state_q)
            ARMED: begin
                // Releases of rngPush are ignored here so the secret stays fixed.
                if (guess_prs) begin
                    too_high_d = bus.guessIn > secret_q;
                    too_low_d  = bus.guessIn < secret_q;
                    match_d    = bus.guessIn == secret_q;
                    if (bus.guessIn == secret_q) begin
                        state_d = WIN;
                    end else begin
                        // Guard keeps the counter from wrapping even if it
                        // were somehow zero while armed.
                        if (tries_q != 3'd0) tries_d = tries_q - 3'd1;
                        if (tries_q <= 3'd1) begin
                            state_d = LOSE;
                            over_d  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                // IDLE, WIN and LOSE all start a fresh game on release;
                // guess presses are ignored.
                if (rng_rel) begin
                    state_d    = ARMED;
                    secret_d   = bus.rngIn;
                    tries_d    = TRIES_INIT;
                    too_high_d = 1'b0;
                    too_low_d  = 1'b0;
                    match_d    = 1'b0;
                    over_d     = 1'b0;
                end
            end
        endcase
    end

    assign bus.armed     = (state_q == ARMED);
    assign bus.tooHigh   = too_high_q;
    assign bus.tooLow    = too_low_q;
    assign bus.match     = match_q;
    assign bus.gameOver  = over_q;
    assign bus.triesLeft = tries_q;

endmodule

// File: tb/tb_guess_game.sv
// tb_guess_game -- scoreboard bench for guess_game. Each player action
// updates a transaction-level game model, pushes the expected status to a
// queue, and the status is popped and compared once the DUT has settled.
module tb_guess_game;

    localparam int unsigned MAX_TRIES = 5;

    typedef struct {
        string      tag;
        logic       armed;
        logic       hi;
        logic       lo;
        logic       mt;
        logic       ov;
        logic [2:0] tries;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    // Game model state: 0 idle, 1 armed, 2 win, 3 lose.
    int         m_st;
    logic [3:0] m_sec;
    logic [2:0] m_tries;
    logic       m_hi, m_lo, m_mt, m_ov;

    guess_game_if gif ();

    guess_game #(.MAX_TRIES(MAX_TRIES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (gif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag   = tag;
        e.armed = (m_st == 1);
        e.hi    = m_hi;
        e.lo    = m_lo;
        e.mt    = m_mt;
        e.ov    = m_ov;
        e.tries = m_tries;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".armed"},    32'(gif.armed),     32'(e.armed));
            chk({e.tag, ".tooHigh"},  32'(gif.tooHigh),   32'(e.hi));
            chk({e.tag, ".tooLow"},   32'(gif.tooLow),    32'(e.lo));
            chk({e.tag, ".match"},    32'(gif.match),     32'(e.mt));
            chk({e.tag, ".gameOver"}, 32'(gif.gameOver),  32'(e.ov));
            chk({e.tag, ".tries"},    32'(gif.triesLeft), 32'(e.tries));
        end
    endtask

    task automatic do_rng(input string tag, input logic [3:0] v);
        @(negedge clk);
        gif.rngIn   = v;
        gif.rngPush = 1'b0;
        repeat (2) @(negedge clk);
        gif.rngPush = 1'b1;
        if (m_st != 1) begin
            m_st    = 1;
            m_sec   = v;
            m_tries = 3'(MAX_TRIES);
            m_hi = 0; m_lo = 0; m_mt = 0; m_ov = 0;
        end
        push_exp(tag);
        repeat (3) @(negedge clk);
        check_out();
    endtask

    task automatic do_guess(input string tag, input logic [3:0] g, input int hold);
        @(negedge clk);
        gif.guessIn   = g;
        gif.guessPush = 1'b0;
        repeat (hold) @(negedge clk);
        gif.guessPush = 1'b1;
        if (m_st == 1) begin
            m_hi = g > m_sec;
            m_lo = g < m_sec;
            m_mt = g == m_sec;
            if (m_mt) begin
                m_st = 2;
            end else begin
                m_tries = m_tries - 3'd1;
                if (m_tries == 3'd0) begin
                    m_st = 3;
                    m_ov = 1;
                end
            end
        end
        push_exp(tag);
        repeat (3) @(negedge clk);
        check_out();
    endtask

    // Pulse reset away from the clock edge; outputs must clear at once.
    task automatic do_rst(input string tag);
        @(negedge clk);
        #2 rst = 1'b0;
        m_st = 0; m_sec = 0; m_tries = 0;
        m_hi = 0; m_lo = 0; m_mt = 0; m_ov = 0;
        push_exp(tag);
        #1 check_out();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        gif.rngPush = 1'b1; gif.rngIn = 4'd0;
        gif.guessPush = 1'b1; gif.guessIn = 4'd0;
        rst = 1'b1;
        m_st = 0; m_sec = 0; m_tries = 0;
        m_hi = 0; m_lo = 0; m_mt = 0; m_ov = 0;

        do_rst("reset");
        do_guess("idle_guess", 4'd3, 2);

        // Basic game: secret 9.
        do_rng("start9", 4'd9);
        do_guess("g4_low", 4'd4, 2);
        do_guess("g12_high", 4'd12, 2);
        do_guess("g9_win", 4'd9, 2);
        do_guess("win_ignore", 4'd1, 2);

        // Restart from WIN with max secret.
        do_rng("start15", 4'd15);
        do_guess("g15_win", 4'd15, 2);

        // Exhaust all tries with secret 0.
        do_rng("start0", 4'd0);
        for (int i = 0; i < 5; i++) do_guess($sformatf("lose%0d", i), 4'd15, 2);
        do_guess("lose_ignore", 4'd15, 2);

        // Held press counts once; rngPush in ARMED does not move the secret.
        do_rng("start9b", 4'd9);
        do_guess("held", 4'd4, 10);
        do_rng("armed_rng3", 4'd3);
        do_guess("g9_still", 4'd9, 2);

        // Mid-game reset abandons the game.
        do_rng("start7", 4'd7);
        do_guess("r1", 4'd1, 2);
        do_guess("r2", 4'd2, 2);
        do_guess("r3", 4'd3, 2);
        do_rst("mid_rst");
        do_guess("post_rst_ignore", 4'd7, 2);

        // Random games.
        for (int k = 0; k < 3; k++) begin
            do_rng($sformatf("rstart%0d", k), 4'($urandom_range(0, 15)));
            for (int j = 0; j < 6; j++)
                do_guess($sformatf("rg%0d_%0d", k, j), 4'($urandom_range(0, 15)), 1 + j % 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/guess_game.md
GUESS_GAME -- requirements
Module: guess_game

Interface
REQ-001 Parameter MAX_TRIES, default 5, number of wrong guesses allowed per game (range 1..7).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 rngPush  input  1  active-low player button, same signal that drives the RNG stage; its release (0->1) fixes the secret.
REQ-005 rngIn  input  4  current RNG counter value (RNGOut of the RNG stage).
REQ-006 guessPush  input  1  active-low guess-submit button, already access-gated upstream.
REQ-007 guessIn  input  4  player guess value.
REQ-008 armed  output  1  high while a game is in progress (ARMED state).
REQ-009 tooHigh  output  1  last accepted guess > secret.
REQ-010 tooLow  output  1  last accepted guess < secret.
REQ-011 match  output  1  last accepted guess == secret (WIN).
REQ-012 gameOver  output  1  tries exhausted without match (LOSE).
REQ-013 triesLeft  output  3  remaining wrong guesses allowed.

Function
REQ-014 The block SHALL register rngPush and guessPush once per clk (prev samples) and detect events only from registered samples: release = prev 0, current 1; press = prev 1, current 0.
REQ-015 The FSM SHALL have exactly four states: IDLE, ARMED, WIN, LOSE, in a registered state variable.
REQ-016 IDLE: on rngPush release, secret <= rngIn sampled at that edge, triesLeft <= MAX_TRIES, clear tooHigh/tooLow, go ARMED; guessPush presses ignored.
REQ-017 ARMED: on guessPush press, compare guessIn (sampled at that edge) unsigned 4-bit against secret; result flags SHALL update on the next rising edge (1-cycle latency), exactly one of tooHigh/tooLow/match set.
REQ-018 ARMED, guess == secret: go WIN, match=1, triesLeft unchanged.
REQ-019 ARMED, guess != secret: triesLeft decrements by 1; if the decremented value is 0, go LOSE and set gameOver=1, else stay ARMED.
REQ-020 A held guessPush SHALL count as one guess; a new guess requires release then press.
REQ-021 ARMED: rngPush releases SHALL be ignored (secret is not altered mid-game).
REQ-022 WIN/LOSE: result outputs hold; guessPush ignored; rngPush release starts a new game exactly as in REQ-016 (match, gameOver cleared).
REQ-023 Simultaneous rngPush release and guessPush press: state's own rule wins (IDLE/WIN/LOSE take release, ARMED takes press).
REQ-024 triesLeft SHALL never underflow below 0; secret SHALL not be observable on any output.
REQ-025 armed SHALL equal (state == ARMED), combinationally decoded from registered state.

Reset
REQ-026 rst low SHALL immediately force: state IDLE, secret 0, triesLeft 0, armed/tooHigh/tooLow/match/gameOver 0, button prev samples 1 (released).
REQ-027 Reset asserted mid-game SHALL abandon the game; after rst rises the block waits in IDLE for an rngPush release.

Verification
REQ-028 Reset, rngIn=9, rngPush 0->1 -> armed=1, triesLeft=5, flags 0 one cycle later.
REQ-029 Secret 9, guesses 4 then 12 -> tooLow=1 triesLeft=4, then tooHigh=1 triesLeft=3; guess 9 -> match=1, armed=0, triesLeft=3.
REQ-030 Secret 0, five wrong guesses of 15 -> triesLeft 4,3,2,1,0; gameOver=1 after fifth; sixth press ignored.
REQ-031 guessPush held low 10 cycles in ARMED -> exactly one decrement; rngPush toggled in ARMED with rngIn=3 -> secret unchanged (guess 9 still matches).
REQ-032 rst pulsed low during ARMED with triesLeft=2 -> all outputs 0 asynchronously, IDLE; presses ignored until rngPush release.
REQ-033 From WIN, rngPush release with rngIn=15 -> match=0, armed=1, triesLeft=5; guess 15 -> match=1.
